hamming_correct_ctrl: RTL and testbench

- Sequential Hamming(7,4) single-error-correcting receive controller for the Hamming datapath.
- Accepts one 7-bit codeword over a valid/ready handshake and computes the 3-bit syndrome.
- Converts the syndrome to a one-hot error position (3-to-7 decode, position 1..7, none for syndrome 0), flips that bit and returns the 4 data bits plus status over a second valid/ready handshake.
- Sits between the codeword source (channel/register file) and the data consumer.

---
 rtl/hamming_correct_ctrl.sv | 125 ++++++++++++
 tb/tb_hamming_correct_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_correct_ctrl.sv
// Sequential Hamming(7,4) single-error-correcting receive controller.
// Optional corrected-word counter enabled by defining HAM_ERRCNT_EN.
module hamming_correct_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:7]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syn,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [1:7] code_r;
  logic [2:0] syn_r;
  logic       in_ready_r, out_valid_r, out_err_r;
  logic [3:0] out_data_r;
  logic [2:0] out_syn_r;

  // Syndrome {s2,s1,s0}: the position of a single flipped bit, 0 if clean.
  function automatic logic [2:0] calc_syn(input logic [1:7] c);
    return {c[4] ^ c[5] ^ c[6] ^ c[7],
            c[2] ^ c[3] ^ c[6] ^ c[7],
            c[1] ^ c[3] ^ c[5] ^ c[7]};
  endfunction

  // Data bits after XOR with the one-hot error mask; parity positions need no output.
  function automatic logic [3:0] fix_data(input logic [1:7] c, input logic [2:0] syn);
    return {c[7] ^ (syn == 3'd7),
            c[6] ^ (syn == 3'd6),
            c[5] ^ (syn == 3'd5),
            c[3] ^ (syn == 3'd3)};
  endfunction

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = SYND;
        else          state_nxt_s = IDLE;
      end
      SYND:    state_nxt_s = FIX;
      FIX:     state_nxt_s = HOLD;
      HOLD: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      code_r      <= 7'd0;
      syn_r       <= 3'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 4'd0;
      out_err_r   <= 1'b0;
      out_syn_r   <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == HOLD);
      case (state_r)
        IDLE: begin
          if (in_valid) code_r <= in_code;
          else          code_r <= code_r;
        end
        SYND: syn_r <= calc_syn(code_r);
        FIX: begin
          out_data_r <= fix_data(code_r, syn_r);
          out_err_r  <= (syn_r != 3'd0);
          out_syn_r  <= syn_r;
        end
        default: begin
          code_r <= code_r;
          syn_r  <= syn_r;
        end
      endcase
    end
  end

`ifdef HAM_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Saturating count of corrected words.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == FIX) && (syn_r != 3'd0) && (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = {CNT_W{1'b0}};
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign out_syn   = out_syn_r;

endmodule

// File: tb/tb_hamming_correct_ctrl.sv
// Scoreboard bench for hamming_correct_ctrl with a position-index reference model.
// Honours HAM_ERRCNT_EN for the expected err_cnt.
module tb_hamming_correct_ctrl;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:7]       in_code;
  logic [3:0]       out_data;
  logic [2:0]       out_syn;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    logic [3:0]       data;
    logic             err;
    logic [2:0]       syn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   held_v = 0;
  int   tests = 0, fails = 0;
  int   model_cnt = 0;
  int   rdy_mode = 1; // 0 random, 1 always ready, 2 never ready

  hamming_correct_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .out_syn(out_syn), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the syndrome is the XOR of the indices of all set bits.
  function automatic exp_t model(input logic [1:7] cw);
    exp_t e;
    logic [1:7] fx;
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++) if (cw[p]) s = s ^ p;
    fx = cw;
    if (s != 0) fx[s] = ~fx[s];
    e.data = {fx[7], fx[6], fx[5], fx[3]};
    e.err  = (s != 0);
    e.syn  = s[2:0];
`ifdef HAM_ERRCNT_EN
    if (s != 0 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
`endif
    e.cnt  = model_cnt[CNT_W-1:0];
    return e;
  endfunction

  function automatic logic [1:7] encode(input logic [3:0] d);
    logic [1:7] cw;
    int s;
    cw = 7'd0;
    cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
    s = 0;
    for (int p = 1; p <= 7; p++) if (cw[p]) s = s ^ p;
    cw[1] = s[0]; cw[2] = s[1]; cw[4] = s[2];
    return cw;
  endfunction

  // Consumer: drives out_ready mid-cycle so it is stable at both edges.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares each presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
    end else if (out_valid) begin
      if (held_v != 0) begin
        chk("hold_data", 32'(out_data), 32'(held.data));
        chk("hold_syn", 32'(out_syn), 32'(held.syn));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          held = q.pop_front();
          chk("out_data", 32'(out_data), 32'(held.data));
          chk("out_err", 32'(out_err), 32'(held.err));
          chk("out_syn", 32'(out_syn), 32'(held.syn));
          chk("err_cnt", 32'(err_cnt), 32'(held.cnt));
          chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
        held_v = 0;
      end else if (held_v == 0 && q.size() != 0) begin
        held = q[0];
        held_v = 1;
      end
    end
  end

  task automatic send(input logic [1:7] cw);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_code  = cw;
      q.push_back(model(cw));
      @(negedge clk);
      in_valid = 1'b0;
      in_code  = 7'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [1:7] cw;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_code = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_syn", 32'(out_syn), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed: clean, data-bit error, parity-bit error.
    send(7'b1010101);
    send(7'b1010001);
    send(7'b1110101);
    drain();

    // Backpressure with the next word already offered.
    rdy_mode = 2;
    send(encode(4'h6));
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_rise", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_code = encode(4'h9) ^ 7'b0000010;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 1;
    send(encode(4'h9) ^ 7'b0000010);
    drain();

    // Reset while the word sits in SYND: discarded, everything cleared.
    send(encode(4'hF) ^ 7'b0010000);
    rst = 1'b1;
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Five single-error words: counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      cw = encode(4'(i + 3));
      cw[(i % 7) + 1] = ~cw[(i % 7) + 1];
      send(cw);
    end
    drain();

    // Random words with 0, 1 or 2 bit errors and random backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      cw = encode(4'($urandom));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        int p;
        p = $urandom_range(1, 7);
        cw[p] = ~cw[p];
      end
      send(cw);
    end
    drain();
    rdy_mode = 1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
